load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath's data-memory outputs: address, store data and read/write strobes.
- Converts each access into a req/ack transaction on the data bus, with byte lanes, sub-word extraction and ARM-style rotation.
- Stalls the core until the transaction completes, then returns formatted read data into the datapath's result select.
- Owns the bus timeout and the error flag.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without bus_ack before abort. Legal range 1..65535.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- mem_read  input  1  load request from decoder
- mem_write  input  1  store request from decoder
- size  input  2  access size: 00 word, 01 byte, 10 halfword, 11 reserved (treated as word)
- signed_load  input  1  sign-extend byte/halfword loads
- addr  input  32  byte address (datapath ALU result)
- write_data  input  32  store data (register read port 3)
- read_data  output  32  formatted load data to result mux
- stall  output  1  hold PC and register writes
- bus_req  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_ack  input  1  transaction complete; rdata valid same cycle
- bus_rdata  input  32  raw read word
- bus_err  output  1  sticky timeout flag
- align_fault  output  1  one-cycle misalignment pulse (optional feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset, go to IDLE and clear every registered output: read_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, bus_err=0, align_fault=0.
- Reset mid-transaction drops bus_req the next edge. A late bus_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If mem_read|mem_write, latch addr, size, signed_load, direction and lane-formatted store data, then go to REQ.
  - mem_read and mem_write together: treated as a write.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_wdata and bus_be are held stable from the latched values until ack.
  - On bus_ack: a load registers its formatted result into read_data; go to DONE.
  - Timeout counter clears on REQ entry. If it reaches TIMEOUT_CYCLES without ack: drop bus_req, set bus_err (sticky until reset), load read_data=0, go to DONE.
- DONE: stall=0, one cycle only; the core commits. Always returns to IDLE.
- stall = (IDLE & (mem_read|mem_write)) | REQ. It is combinational, so stall rises in the same cycle as the request.
- Latency: minimum 3 cycles per access (IDLE, REQ with ack in the same cycle, DONE). Each extra wait cycle adds 1.
- read_data holds its last value outside DONE. Stores leave read_data unchanged.
- Store lanes:
  - word: be=1111, wdata=write_data.
  - byte: be=0001<<addr[1:0], wdata={4{write_data[7:0]}}.
  - halfword: be = addr[1] ? 1100 : 0011, wdata={2{write_data[15:0]}}.
- Load extract:
  - byte: bus_rdata>>(8*addr[1:0]), then [7:0] zero- or sign-extended.
  - halfword: lane selected by addr[1], then 16 bits extended.
  - word: bus_rdata rotated right by 8*addr[1:0].
- Addresses never wrap. bus_addr only drops the low bits.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined:
  - Flags a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, in IDLE.
  - No bus transaction is issued. The FSM goes directly to DONE with align_fault=1 for that cycle.
  - read_data and memory are unchanged; bus_err is not set.
  - Minimum latency 2 cycles.
- Undefined:
  - align_fault is tied to 0.
  - Misaligned word loads rotate and stores ignore addr[1:0]; halfword accesses ignore addr[0].

Decomposition:
- Package lsu_pkg:
  - size_e enum (SZ_WORD, SZ_BYTE, SZ_HALF).
  - state_e enum (IDLE, REQ, DONE).
  - BE_WORD/BE_LO/BE_HI constants.
  - Default timeout constant.
- Sub-module lsu_lane_align: purely combinational store-lane replication, byte-enable generation and load extract/extend/rotate. The FSM wraps it.

Test Plan:
- Word store, addr=0x100, write_data=0x11223344, ack after 2 waits -> bus_be=1111, bus_wdata=0x11223344, bus_addr=0x100. stall high for 4 cycles, low in DONE.
- Signed byte load, addr=0x203, bus_rdata=0x80AABBCC, ack immediate -> read_data=0xFFFFFF80. Same with signed_load=0 -> 0x00000080.
- Halfword store, addr=0x302, write_data=0x0000BEEF -> bus_be=1100, bus_wdata=0xBEEFBEEF.
- Word load, addr=0x401, bus_rdata=0x44332211, macro off -> read_data=0x11443322. Macro on -> no bus_req, align_fault pulse, read_data unchanged.
- No ack with TIMEOUT_CYCLES=4 -> bus_req drops after 4 REQ cycles, bus_err=1 and stays 1, read_data=0. reset clears bus_err.
- reset asserted during REQ, then ack the following cycle -> bus_req=0, state IDLE, read_data=0, stall=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The optional alignment check is enabled by defining LSU_ALIGN_CHECK_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // Reserved size 2'b11 is handled as a word access.
    function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) ||
               (((sz == SZ_WORD) || (sz == 2'b11)) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational store-lane replication, byte-enable generation and
// load extract / sign-extend / rotate for the load/store unit.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rot;

    assign w_shamt = {i_addr_lo, 3'b000};
    assign w_byte  = 8'(i_rdata >> w_shamt);
    assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_rot   = 32'({i_rdata, i_rdata} >> w_shamt);

    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = w_rot;
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_addr_lo[1] ? BE_HI : BE_LO;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath memory strobes into req/ack bus transactions.
// Define LSU_ALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        signed_load,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        align_fault
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_read_data;
    logic        r_bus_err;
    logic        r_align_fault;

    logic        w_idle;
    logic        w_access;
    logic        w_misalign;
    logic [1:0]  w_size;
    logic [1:0]  w_lo;
    logic        w_signed;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    assign w_idle   = (r_state == IDLE);
    assign w_access = mem_read | mem_write;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = lsu_misaligned(size, addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Live inputs format the store in IDLE; latched fields format the load in REQ.
    assign w_size   = w_idle ? size        : r_size;
    assign w_lo     = w_idle ? addr[1:0]   : r_addr_lo;
    assign w_signed = w_idle ? signed_load : r_signed;

    lsu_lane_align u_align (
        .i_size    (w_size),
        .i_addr_lo (w_lo),
        .i_signed  (w_signed),
        .i_wdata   (write_data),
        .i_rdata   (bus_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_idle && w_access) begin
            r_addr_lo <= addr[1:0];
            r_size    <= size;
            r_signed  <= signed_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_be      <= '0;
            r_read_data   <= '0;
            r_bus_err     <= 1'b0;
            r_align_fault <= 1'b0;
        end else begin
            r_align_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_misalign) begin
                            r_align_fault <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_wdata <= w_wdata;
                            r_bus_be    <= w_be;
                            r_cnt       <= '0;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_read_data <= w_load;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == TO_LAST) begin
                        // Abort: the core still commits, with zero load data and a sticky error.
                        r_bus_req   <= 1'b0;
                        r_bus_err   <= 1'b1;
                        r_read_data <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall       = (w_idle & w_access) | (r_state == REQ);
    assign read_data   = r_read_data;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_be      = r_bus_be;
    assign bus_err     = r_bus_err;
    assign align_fault = r_align_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected results,
// a negedge monitor checks bus fields at ack and results at commit.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signed_load = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;
    logic        align_fault;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .signed_load(signed_load), .addr(addr), .write_data(write_data),
        .read_data(read_data), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err), .align_fault(align_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          mis;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_rd = '0;
    bit          m_err = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-oriented view of the bus word.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input int sz, input int a, input bit sg);
        logic [31:0] r;
        logic [7:0]  b;
        logic [15:0] h;
        r = '0;
        if (sz == 1) begin
            b = rd[8*a +: 8];
            r = {24'd0, b};
            if (sg && b >= 8'd128) r = r + 32'hFFFFFF00;
        end else if (sz == 2) begin
            h = (a >= 2) ? rd[31:16] : rd[15:0];
            r = {16'd0, h};
            if (sg && h >= 16'd32768) r = r + 32'hFFFF0000;
        end else begin
            for (int i = 0; i < 4; i++) r[8*i +: 8] = rd[8*((i + a) % 4) +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input int a);
        if (sz == 1) return 4'(1 << a);
        if (sz == 2) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
        if (sz == 1) return 32'(wd[7:0] * 32'h01010101);
        if (sz == 2) return 32'(wd[15:0] * 32'h00010001);
        return wd;
    endfunction

    function automatic bit model_mis(input int sz, input int a);
`ifdef LSU_ALIGN_CHECK_EN
        return (sz == 2 && (a % 2) == 1) || ((sz == 0 || sz == 3) && a != 0);
`else
        return (sz < 0) && (a < 0);
`endif
    endfunction

    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits);
        exp_t e;
        int   a;
        int   n;
        bit   tmo;
        a       = int'(ad[1:0]);
        e.we    = wr;
        e.mis   = model_mis(int'(sz), a);
        tmo     = (waits >= TO) && !e.mis;
        e.baddr = {ad[31:2], 2'b00};
        e.be    = model_be(int'(sz), a);
        e.wdata = model_wdata(int'(sz), wd);
        if (e.mis)     e.lat = 1;
        else if (tmo)  e.lat = 1 + TO;
        else           e.lat = waits + 2;
        if (!e.mis) begin
            if (tmo) begin
                m_rd  = '0;
                m_err = 1'b1;
            end else if (!wr) begin
                m_rd = model_load(rdat, int'(sz), a, sg);
            end
        end
        e.rd  = m_rd;
        e.err = m_err;
        q.push_back(e);

        mem_read = rd; mem_write = wr; size = sz; signed_load = sg;
        addr = ad; write_data = wd; bus_rdata = rdat;
        @(posedge clk); #1;
        n = 0;
        while (stall && n < 40) begin
            bus_ack = (n == waits);
            @(posedge clk); #1;
            n++;
        end
        if (stall) begin
            total++; bad++;
            $display("FAIL access_bound: stall still %b after %0d cycles, want 0", stall, n);
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    exp_t me;
    int   scnt = 0;
    bit   prev = 1'b0;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev = 1'b0;
            scnt = 0;
        end else begin
            if (bus_req && bus_ack) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: queue size 0, want 1");
                end else begin
                    chk("bus_we", 32'(bus_we), 32'(q[0].we));
                    chk("bus_addr", bus_addr, q[0].baddr);
                    if (q[0].we) begin
                        chk("bus_be", 32'(bus_be), 32'(q[0].be));
                        chk("bus_wdata", bus_wdata, q[0].wdata);
                    end
                end
            end
            if (bus_req && q.size() > 0 && q[0].mis) begin
                total++; bad++;
                $display("FAIL misaligned_req: bus_req 1, want 0");
            end
            if (stall) begin
                scnt++;
            end else if (prev) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_commit: queue size 0, want 1");
                end else begin
                    me = q.pop_front();
                    chk("read_data", read_data, me.rd);
                    chk("bus_err", 32'(bus_err), 32'(me.err));
                    chk("align_fault", 32'(align_fault), 32'(me.mis));
                    chk("done_bus_req", 32'(bus_req), 32'd0);
                    chk("stall_cycles", 32'(scnt), 32'(me.lat));
                end
                scnt = 0;
            end
            prev = stall;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_align_fault", 32'(align_fault), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        mon_en = 1'b1;

        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h100, 32'h11223344, 32'h0, 2);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 32'h80AABBCC, 0);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 32'h80AABBCC, 0);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h302, 32'h0000BEEF, 32'h0, 1);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h401, 32'h0, 32'h44332211, 0);

        for (int k = 0; k < 40; k++) begin
            int op;
            op = int'($urandom_range(0, 2));
            access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 32'hDEADBEEF, 99);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h600, 32'h000000A5, 32'h0, 0);

        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("clr_bus_err", 32'(bus_err), 32'd0);
        chk("clr_read_data", read_data, 32'd0);
        m_rd = '0;
        m_err = 1'b0;

        mem_read = 1'b1; size = 2'b00; addr = 32'h700; bus_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("mid_req_active", 32'(bus_req), 32'd1);
        reset = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; bus_ack = 1'b1;
        chk("mid_bus_req", 32'(bus_req), 32'd0);
        chk("mid_stall", 32'(stall), 32'd0);
        chk("mid_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_bus_req", 32'(bus_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        chk("late_ack_read_data", read_data, 32'd0);
        chk("late_ack_bus_err", 32'(bus_err), 32'd0);

        mon_en = 1'b1;
        access(1'b1, 1'b0, 2'b10, 1'b1, 32'h802, 32'h0, 32'h9ABC1234, 1);
        mon_en = 1'b0;

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
